pmem_responder: RTL and testbench
=================================

# pmem_responder

Physical-memory responder for the LC-3b cache hierarchy. It sits below the two-way cache controller and serves line-sized `pmem_read`/`pmem_write` requests from a line-addressed storage array. Each request completes after a fixed, parameterized latency with a one-cycle `pmem_resp` pulse. It is used as the backing store in simulation and FPGA builds.

## Interface
Parameters:
- `LINE_BITS`, 128, width of one cache line in bits.
- `ADDR_BITS`, 16, byte address width.
- `OFFSET_BITS`, 4, byte-offset bits within a line. These are ignored for indexing.
- `INDEX_BITS`, 8, line-index bits. Depth is 2^INDEX_BITS lines.
- `LATENCY`, 10, cycles from the first request cycle to the `pmem_resp` cycle. Must be ≥ 2.

Ports:
- `clk` input 1: sole clock; all state updates on its rising edge.
- `reset_n` input 1: reset, asynchronous and active-low.
- `pmem_read` input 1: line read request, held until `pmem_resp`.
- `pmem_write` input 1: line write request, held until `pmem_resp`.
- `pmem_address` input ADDR_BITS: byte address of the line.
- `pmem_wdata` input LINE_BITS: write data.
- `pmem_rdata` output LINE_BITS: read data, registered.
- `pmem_resp` output 1: transaction-complete pulse, exactly one cycle.
- `req_count` output 16: count of completed transactions.
- `protocol_err` output 1: sticky protocol-violation flag.

## Operation
- Line index = `pmem_address[OFFSET_BITS +: INDEX_BITS]`. Higher address bits are ignored, so addresses differing only in those bits alias to the same line.
- FSM states are IDLE, WAIT and RESP.
- IDLE:
  - If `pmem_read | pmem_write` is high, latch the op, index and `pmem_wdata`.
  - Load `cnt` with LATENCY-2 and go to WAIT.
  - If both request lines are high, the op is a write.
- WAIT:
  - If `cnt == 0`, go to RESP. Otherwise decrement `cnt`.
  - On the WAIT→RESP edge:
    - A write stores the latched data into `array[index]`.
    - A read loads `pmem_rdata` from `array[index]`.
- RESP:
  - `pmem_resp` = 1 and `req_count` increments; it wraps 0xFFFF→0x0000.
  - Always go to IDLE.
- IDLE samples requests in the cycle right after RESP. A back-to-back request (write-back followed by fill) therefore starts with no dead cycle.
- The latched transaction is authoritative. Input changes during WAIT/RESP are ignored, and a request dropped mid-transaction still completes and pulses `pmem_resp`.
- `pmem_rdata` holds its value until the next read reaches RESP. Writes do not change it.

## Timing
- Reset values:
  - FSM state IDLE
  - `cnt` 0
  - `pmem_resp` 0
  - `pmem_rdata` 0
  - `req_count` 0
  - `protocol_err` 0
- Array contents are not reset and are X at power-up.
- Reset asserted mid-transaction aborts the transaction immediately. A pending write is not committed.
- Latency:
  - Cycle 0 is the first cycle a request is high in IDLE.
  - `pmem_resp` is high in cycle LATENCY.
  - `pmem_rdata` is valid in that same cycle.
- Read-after-write to the same line returns the new data. The write commits before its RESP cycle.
- `pmem_resp` is never high in two consecutive cycles.
- `pmem_resp` is never high in IDLE or WAIT.

## Configuration
- `PMEM_PROTOCOL_CHECK_EN` defined: `protocol_err` is set, sticky until reset, one cycle after any of these is observed:
  - `pmem_read & pmem_write` in any cycle.
  - The latched request line low, or `pmem_address` changed, during WAIT.
- `PMEM_PROTOCOL_CHECK_EN` undefined: `protocol_err` is tied to 0 and no check logic is built. All other behaviour is identical.

## Test plan
All scenarios use LATENCY=4 unless stated otherwise.
- Reset, then write 0x1111…1111 to 0x0040 with request held.
  - Required: `pmem_resp` only in cycle 4, and `req_count` = 1.
- Read 0x0040 after the write.
  - Required: `pmem_rdata` = 0x1111…1111 in the resp cycle.
  - Read 0x1040: returns the same data (alias).
- Write 0xAAAA… to 0x0080, resp, then read 0x0080 asserted the next cycle.
  - Required: read resp exactly 4 cycles later with 0xAAAA…, and `pmem_resp` not high in the intervening cycles.
- Drop `pmem_read` in cycle 2 of a read.
  - Required: `pmem_resp` still pulses in cycle 4.
  - `protocol_err` = 1 with macro, 0 without.
- Pulse `reset_n` low in cycle 2 of a write of 0x5555… to 0x00C0.
  - Required: no `pmem_resp`, and all outputs reset.
  - A later read of 0x00C0 does not return 0x5555….
- LATENCY=2, 0x10000 back-to-back reads.
  - Required: resp every 3rd cycle, and `req_count` wraps to 0x0000.

Source files
------------

// File: rtl/pmem_responder.sv
// -----------------------------------------------------------------------------
// pmem_responder
// Line-addressed physical-memory model serving pmem_read/pmem_write requests
// from the LC-3b cache controller. Every request completes LATENCY cycles
// after it is first seen in IDLE, with a single-cycle pmem_resp pulse.
//
// Optional feature macro: PMEM_PROTOCOL_CHECK_EN
//   defined   -> sticky protocol_err monitor is built
//   undefined -> protocol_err tied low, no check logic
//
// Ports:
//   clk          : rising-edge clock
//   reset_n      : asynchronous active-low reset
//   pmem_read    : line read request, held until pmem_resp
//   pmem_write   : line write request, held until pmem_resp (wins over read)
//   pmem_address : byte address; bits [OFFSET_BITS +: INDEX_BITS] pick the line
//   pmem_wdata   : line write data
//   pmem_rdata   : registered read data, held until the next read completes
//   pmem_resp    : one-cycle completion pulse
//   req_count    : completed-transaction counter, wraps at 16 bits
//   protocol_err : sticky protocol-violation flag
// -----------------------------------------------------------------------------
module pmem_responder #(
    parameter int LINE_BITS   = 128,
    parameter int ADDR_BITS   = 16,
    parameter int OFFSET_BITS = 4,
    parameter int INDEX_BITS  = 8,
    parameter int LATENCY     = 10
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 pmem_read,
    input  logic                 pmem_write,
    input  logic [ADDR_BITS-1:0] pmem_address,
    input  logic [LINE_BITS-1:0] pmem_wdata,
    output logic [LINE_BITS-1:0] pmem_rdata,
    output logic                 pmem_resp,
    output logic [15:0]          req_count,
    output logic                 protocol_err
);

    localparam int DEPTH = 1 << INDEX_BITS;
    localparam int CNT_W = $clog2(LATENCY);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_op_write;
    logic [INDEX_BITS-1:0] r_index;
    logic [LINE_BITS-1:0]  r_wdata;
    logic [LINE_BITS-1:0]  r_rdata;
    logic                  r_resp;
    logic [15:0]           r_count;
    logic [LINE_BITS-1:0]  r_mem [0:DEPTH-1];

    logic                  w_req;
    logic                  w_commit;
    logic                  w_unused;

    assign w_req    = pmem_read | pmem_write;
    // Last WAIT cycle: the array access happens on the edge into RESP.
    assign w_commit = (r_state == ST_WAIT) && (r_cnt == '0);
    // Offset and upper alias bits take no part in indexing.
    assign w_unused = ^pmem_address;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_next_state = ST_WAIT;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (w_commit) begin
                    w_next_state = ST_RESP;
                end else begin
                    w_next_state = ST_WAIT;
                end
            end
            ST_RESP: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Transaction latch, latency counter, read data, response and counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt      <= '0;
            r_op_write <= 1'b0;
            r_index    <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_resp     <= 1'b0;
            r_count    <= 16'd0;
        end else begin
            r_resp <= w_commit;
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_op_write <= pmem_write;
                        r_index    <= pmem_address[OFFSET_BITS +: INDEX_BITS];
                        r_wdata    <= pmem_wdata;
                        r_cnt      <= CNT_W'(LATENCY - 2);
                    end
                end
                ST_WAIT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else if (!r_op_write) begin
                        r_rdata <= r_mem[r_index];
                    end
                end
                ST_RESP: r_count <= r_count + 16'd1;
                default: r_cnt <= '0;
            endcase
        end
    end

    // Storage array; not reset. A reset aborts the FSM first, so no commit.
    always_ff @(posedge clk) begin
        if (w_commit && r_op_write) begin
            r_mem[r_index] <= r_wdata;
        end
    end

    assign pmem_rdata = r_rdata;
    assign pmem_resp  = r_resp;
    assign req_count  = r_count;

`ifdef PMEM_PROTOCOL_CHECK_EN
    logic [ADDR_BITS-1:0] r_addr;
    logic                 r_perr;
    logic                 w_viol;

    // A held request must keep its line high and its address stable in WAIT.
    assign w_viol = (pmem_read & pmem_write)
                  | ((r_state == ST_WAIT)
                     && ((r_op_write ? !pmem_write : !pmem_read)
                         || (pmem_address != r_addr)));

    // Full address capture and sticky violation flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr <= '0;
            r_perr <= 1'b0;
        end else begin
            if ((r_state == ST_IDLE) && w_req) begin
                r_addr <= pmem_address;
            end
            r_perr <= r_perr | w_viol;
        end
    end

    assign protocol_err = r_perr;
`else
    assign protocol_err = 1'b0;
`endif

endmodule

// File: tb/tb_pmem_responder.sv
module tb_pmem_responder;

    localparam int L = 4;

    logic         clk;
    logic         reset_n;
    logic         rd, wr;
    logic [15:0]  addr;
    logic [127:0] wdata;
    logic [127:0] rdata;
    logic         resp;
    logic [15:0]  cnt;
    logic         perr;

    logic         rd2;
    logic         wr2;
    logic [15:0]  addr2;
    logic [127:0] wdata2;
    logic [127:0] rdata2;
    logic         resp2;
    logic [15:0]  cnt2;
    logic         perr2;

    int n_checks;
    int n_fail;
    logic [127:0] exp_q[$];
    logic exp_perr;

    pmem_responder #(.LATENCY(L)) dut (
        .clk(clk), .reset_n(reset_n), .pmem_read(rd), .pmem_write(wr),
        .pmem_address(addr), .pmem_wdata(wdata), .pmem_rdata(rdata),
        .pmem_resp(resp), .req_count(cnt), .protocol_err(perr)
    );

    pmem_responder #(.LATENCY(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .pmem_read(rd2), .pmem_write(wr2),
        .pmem_address(addr2), .pmem_wdata(wdata2), .pmem_rdata(rdata2),
        .pmem_resp(resp2), .req_count(cnt2), .protocol_err(perr2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drives one request starting in the current (IDLE) cycle, observes
    // cycles 1..L and one trailing IDLE cycle.
    task automatic run_txn(input logic is_wr, input logic both, input logic [15:0] a,
                           input logic [127:0] d, input int drop_at,
                           output int first_resp, output int n_resp,
                           output logic [127:0] rd_at_resp);
        wr = is_wr | both;
        rd = ~is_wr | both;
        addr = a;
        wdata = d;
        first_resp = -1;
        n_resp = 0;
        rd_at_resp = 'x;
        for (int k = 1; k <= L; k++) begin
            tick();
            if (resp === 1'b1) begin
                n_resp++;
                if (first_resp < 0) begin
                    first_resp = k;
                    rd_at_resp = rdata;
                end
            end
            if (k == drop_at) begin
                rd = 1'b0;
                wr = 1'b0;
            end
        end
        rd = 1'b0;
        wr = 1'b0;
        tick();
        if (resp !== 1'b0) n_resp++;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        rd = 1'b0; wr = 1'b0; addr = 16'h0000; wdata = 128'd0;
        rd2 = 1'b0; wr2 = 1'b0; addr2 = 16'h0000; wdata2 = 128'd0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        n_checks++; if (rdata !== 128'd0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        n_checks++; if (resp !== 1'b0) begin n_fail++; $display("FAIL reset_resp: got %b want 0", resp); end
        n_checks++; if (cnt !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %h want 0", cnt); end
        n_checks++; if (perr !== 1'b0) begin n_fail++; $display("FAIL reset_perr: got %b want 0", perr); end
        n_checks++; if (cnt2 !== 16'd0) begin n_fail++; $display("FAIL reset_count2: got %h want 0", cnt2); end
    endtask

    task automatic test_write;
        int fr, nr;
        logic [127:0] d;
        run_txn(1'b1, 1'b0, 16'h0040, {8{16'h1111}}, 0, fr, nr, d);
        n_checks++; if (fr != L) begin n_fail++; $display("FAIL write_resp_cycle: got %0d want %0d", fr, L); end
        n_checks++; if (nr != 1) begin n_fail++; $display("FAIL write_resp_pulses: got %0d want 1", nr); end
        n_checks++; if (cnt !== 16'd1) begin n_fail++; $display("FAIL write_count: got %h want 1", cnt); end
    endtask

    task automatic test_read_alias;
        int fr, nr;
        logic [127:0] d, e;
        exp_q.push_back({8{16'h1111}});
        run_txn(1'b0, 1'b0, 16'h0040, 128'd0, 0, fr, nr, d);
        e = exp_q.pop_front();
        n_checks++; if (fr != L) begin n_fail++; $display("FAIL read_resp_cycle: got %0d want %0d", fr, L); end
        n_checks++; if (d !== e) begin n_fail++; $display("FAIL read_data: got %h want %h", d, e); end
        exp_q.push_back({8{16'h1111}});
        run_txn(1'b0, 1'b0, 16'h1040, 128'd0, 0, fr, nr, d);
        e = exp_q.pop_front();
        n_checks++; if (nr != 1) begin n_fail++; $display("FAIL alias_resp_pulses: got %0d want 1", nr); end
        n_checks++; if (d !== e) begin n_fail++; $display("FAIL alias_data: got %h want %h", d, e); end
        n_checks++; if (cnt !== 16'd3) begin n_fail++; $display("FAIL alias_count: got %h want 3", cnt); end
    endtask

    task automatic test_back_to_back;
        int fr, nr;
        logic [127:0] d, e;
        run_txn(1'b1, 1'b0, 16'h0080, {8{16'hAAAA}}, 0, fr, nr, d);
        n_checks++; if (fr != L || nr != 1) begin n_fail++; $display("FAIL b2b_write_resp: got cycle %0d pulses %0d want %0d/1", fr, nr, L); end
        n_checks++; if (rdata !== {8{16'h1111}}) begin n_fail++; $display("FAIL rdata_hold_on_write: got %h want %h", rdata, {8{16'h1111}}); end
        exp_q.push_back({8{16'hAAAA}});
        run_txn(1'b0, 1'b0, 16'h0080, 128'd0, 0, fr, nr, d);
        e = exp_q.pop_front();
        n_checks++; if (fr != L) begin n_fail++; $display("FAIL b2b_read_resp_cycle: got %0d want %0d", fr, L); end
        n_checks++; if (nr != 1) begin n_fail++; $display("FAIL b2b_read_resp_pulses: got %0d want 1", nr); end
        n_checks++; if (d !== e) begin n_fail++; $display("FAIL b2b_read_data: got %h want %h", d, e); end
    endtask

    task automatic test_drop;
        int fr, nr;
        logic [127:0] d, e;
        n_checks++; if (perr !== 1'b0) begin n_fail++; $display("FAIL perr_before_drop: got %b want 0", perr); end
        exp_q.push_back({8{16'hAAAA}});
        run_txn(1'b0, 1'b0, 16'h0080, 128'd0, 2, fr, nr, d);
        e = exp_q.pop_front();
        n_checks++; if (fr != L || nr != 1) begin n_fail++; $display("FAIL drop_resp: got cycle %0d pulses %0d want %0d/1", fr, nr, L); end
        n_checks++; if (d !== e) begin n_fail++; $display("FAIL drop_data: got %h want %h", d, e); end
        n_checks++; if (perr !== exp_perr) begin n_fail++; $display("FAIL drop_perr: got %b want %b", perr, exp_perr); end
    endtask

    task automatic test_both_high;
        int fr, nr;
        logic [127:0] d, e;
        run_txn(1'b1, 1'b1, 16'h0100, {8{16'h3333}}, 0, fr, nr, d);
        n_checks++; if (fr != L || nr != 1) begin n_fail++; $display("FAIL both_resp: got cycle %0d pulses %0d want %0d/1", fr, nr, L); end
        exp_q.push_back({8{16'h3333}});
        run_txn(1'b0, 1'b0, 16'h0100, 128'd0, 0, fr, nr, d);
        e = exp_q.pop_front();
        n_checks++; if (d !== e) begin n_fail++; $display("FAIL both_is_write: got %h want %h", d, e); end
        n_checks++; if (cnt !== 16'd8) begin n_fail++; $display("FAIL both_count: got %h want 8", cnt); end
    endtask

    task automatic test_reset_abort;
        int fr, nr, extra;
        logic [127:0] d;
        wr = 1'b1; rd = 1'b0; addr = 16'h00C0; wdata = {8{16'h5555}};
        extra = 0;
        tick();
        tick();
        if (resp !== 1'b0) extra++;
        reset_n = 1'b0;
        wr = 1'b0;
        #2;
        n_checks++; if (rdata !== 128'd0) begin n_fail++; $display("FAIL abort_rdata: got %h want 0", rdata); end
        n_checks++; if (cnt !== 16'd0 || perr !== 1'b0) begin n_fail++; $display("FAIL abort_count_perr: got %h/%b want 0/0", cnt, perr); end
        reset_n = 1'b1;
        for (int k = 0; k < L + 2; k++) begin
            tick();
            if (resp !== 1'b0) extra++;
        end
        n_checks++; if (extra != 0) begin n_fail++; $display("FAIL abort_no_resp: got %0d pulses want 0", extra); end
        run_txn(1'b0, 1'b0, 16'h00C0, 128'd0, 0, fr, nr, d);
        n_checks++; if (fr != L) begin n_fail++; $display("FAIL abort_read_resp: got %0d want %0d", fr, L); end
        n_checks++; if (d === {8{16'h5555}}) begin n_fail++; $display("FAIL abort_not_committed: got %h want not %h", d, {8{16'h5555}}); end
        n_checks++; if (cnt !== 16'd1) begin n_fail++; $display("FAIL abort_count: got %h want 1", cnt); end
    endtask

    task automatic test_wrap;
        int bad, nr;
        logic [15:0] c5, cbefore;
        bad = 0; nr = 0; c5 = 16'd0; cbefore = 16'd0;
        rd2 = 1'b1;
        for (int t = 0; t < 65536; t++) begin
            tick();
            if (resp2 !== 1'b0) bad++;
            tick();
            if (resp2 === 1'b1) nr++; else bad++;
            if (t == 65535) rd2 = 1'b0;
            tick();
            if (resp2 !== 1'b0) bad++;
            if (t == 4) c5 = cnt2;
            if (t == 65534) cbefore = cnt2;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL wrap_cadence: got %0d bad cycles want 0", bad); end
        n_checks++; if (nr != 65536) begin n_fail++; $display("FAIL wrap_resp_total: got %0d want 65536", nr); end
        n_checks++; if (c5 !== 16'd5) begin n_fail++; $display("FAIL wrap_count5: got %h want 5", c5); end
        n_checks++; if (cbefore !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_count_ffff: got %h want ffff", cbefore); end
        n_checks++; if (cnt2 !== 16'h0000) begin n_fail++; $display("FAIL wrap_count_zero: got %h want 0", cnt2); end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
`ifdef PMEM_PROTOCOL_CHECK_EN
        exp_perr = 1'b1;
`else
        exp_perr = 1'b0;
`endif
        test_reset();
        test_write();
        test_read_alias();
        test_back_to_back();
        test_drop();
        test_both_high();
        test_reset_abort();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
